// File: rtl/core_pkg.sv
// Shared fetch/decode codes for the core pipeline.
// Selection codes, redirect codes, NOP encoding and fetch states.
package core_pkg;

  typedef enum logic [1:0] {
    SEL_PASS = 2'b00,
    SEL_NOP  = 2'b01,
    SEL_HOLD = 2'b10
  } inst_sel_e;

  typedef enum logic [1:0] {
    PC_SEQ  = 2'b00,
    PC_BR   = 2'b01,
    PC_JAL  = 2'b10,
    PC_JALR = 2'b11
  } pc_sel_e;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'b00,
    ST_RUN   = 2'b01,
    ST_FLUSH = 2'b10
  } fetch_state_e;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;

endpackage

// File: rtl/pc_target.sv
// Redirect target masking and word-alignment check.
// Purely combinational; a misaligned target never redirects.
module pc_target
  import core_pkg::*;
(
  input  logic [1:0]  pc_sel,
  input  logic [31:0] target,
  output logic [31:0] eff_target,
  output logic        redirect,
  output logic        misalign
);

  logic req;

  assign req = (pc_sel != PC_SEQ);

  assign eff_target = (pc_sel == PC_JALR) ?
                      (target & ~32'h1) : target;

  assign redirect = req & ~eff_target[1];
  assign misalign = req &  eff_target[1];

endmodule

// File: rtl/pc_mgmt.sv
// Program counter and fetch sequencing stage.
// Drives imem address and tells inst_mgmt what to do with rdata.
module pc_mgmt
  import core_pkg::*;
#(
  parameter logic [31:0] RESET_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic [1:0]  pc_sel,
  input  logic [31:0] target,
  output logic [31:0] imem_addr,
  output logic [31:0] pc_if,
  output logic [1:0]  inst_sel,
  output logic        fetch_valid,
  output logic        misalign
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  pcif_q;
  logic [31:0]  addr;
  logic [31:0]  eff;
  logic         tgt_redir;
  logic         tgt_mis;
  inst_sel_e    sel;
  logic         mis;

  pc_target u_target (
    .pc_sel     (pc_sel),
    .target     (target),
    .eff_target (eff),
    .redirect   (tgt_redir),
    .misalign   (tgt_mis)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_BOOT;
      pc_q    <= RESET_ADDR;
      pcif_q  <= RESET_ADDR;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      pcif_q  <= addr;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q + 32'd4;
    addr    = pc_q;
    sel     = SEL_NOP;
    mis     = 1'b0;
    unique case (state_q)
      ST_BOOT: state_d = ST_RUN;
      ST_RUN: begin
        mis = tgt_mis;
        if (tgt_redir) begin
          pc_d    = eff;
          state_d = ST_FLUSH;
        end else if (stall) begin
          // re-read the word on rdata so no bubble follows
          pc_d = pc_q;
          addr = pcif_q;
          sel  = SEL_HOLD;
        end else begin
          sel = SEL_PASS;
        end
      end
      ST_FLUSH: begin
        mis = tgt_mis;
        if (tgt_redir) pc_d = eff;
        else state_d = ST_RUN;
      end
      default: state_d = ST_BOOT;
    endcase
  end

  assign imem_addr   = addr;
  assign pc_if       = pcif_q;
  assign inst_sel    = sel;
  assign fetch_valid = (sel == SEL_PASS);
  assign misalign    = mis;

endmodule
